// File: rtl/dcache_miss_ctrl.sv
// Data-cache miss handler: stalls the pipeline, writes back a dirty victim
// line, refills the missing line word by word and counts miss events.
module dcache_miss_ctrl #(
    parameter int WORDS  = 4,
    parameter int ADDR_W = 32
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       req_valid,
    input  logic                       hit,
    input  logic                       victim_dirty,
    input  logic [ADDR_W-1:0]          miss_addr,
    input  logic [ADDR_W-1:0]          victim_addr,
    input  logic [31:0]                victim_word,
    output logic [$clog2(WORDS)-1:0]   line_idx,
    output logic                       mem_req,
    output logic                       mem_we,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [31:0]                mem_wdata,
    input  logic [31:0]                mem_rdata,
    input  logic                       mem_ack,
    output logic                       fill_we,
    output logic [31:0]                fill_data,
    output logic                       fill_done,
    output logic                       stall,
    output logic [31:0]                miss_count,
    output logic [31:0]                wb_count
);

    localparam int IDX_W = $clog2(WORDS);
    localparam int OFF   = IDX_W + 2;

    localparam logic [ADDR_W-1:0] BASE_MASK = {{(ADDR_W-OFF){1'b1}}, {OFF{1'b0}}};
    localparam logic [IDX_W-1:0]  LAST      = IDX_W'(WORDS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WB   = 2'd1;
    localparam logic [1:0] S_FILL = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        state_q;
    logic [IDX_W-1:0]  idx_q;
    logic [ADDR_W-1:0] fill_base_q;
    logic [ADDR_W-1:0] wb_base_q;
    logic [31:0]       miss_cnt_q;
    logic [31:0]       wb_cnt_q;
    logic              miss;
    logic [ADDR_W-1:0] word_off;

    assign miss       = (state_q == S_IDLE) && req_valid && !hit;
    assign word_off   = ADDR_W'({idx_q, 2'b00});
    assign miss_count = miss_cnt_q;
    assign wb_count   = wb_cnt_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            fill_base_q <= '0;
            wb_base_q   <= '0;
            miss_cnt_q  <= '0;
            wb_cnt_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (miss) begin
                        fill_base_q <= miss_addr & BASE_MASK;
                        wb_base_q   <= victim_addr & BASE_MASK;
                        idx_q       <= '0;
                        state_q     <= victim_dirty ? S_WB : S_FILL;
                        if (miss_cnt_q != '1)
                            miss_cnt_q <= miss_cnt_q + 32'd1;
                        if (victim_dirty && wb_cnt_q != '1)
                            wb_cnt_q <= wb_cnt_q + 32'd1;
                    end
                end
                S_WB: begin
                    // index wraps to 0 on the last word, ready for the refill
                    if (mem_ack) begin
                        idx_q <= idx_q + IDX_W'(1);
                        if (idx_q == LAST)
                            state_q <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (mem_ack) begin
                        idx_q <= idx_q + IDX_W'(1);
                        if (idx_q == LAST)
                            state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        line_idx  = idx_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        fill_we   = 1'b0;
        fill_data = '0;
        fill_done = 1'b0;
        stall     = 1'b0;
        case (state_q)
            S_IDLE: begin
                stall = miss;
            end
            S_WB: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = wb_base_q + word_off;
                mem_wdata = victim_word;
                stall     = 1'b1;
            end
            S_FILL: begin
                mem_req   = 1'b1;
                mem_addr  = fill_base_q + word_off;
                fill_we   = mem_ack;
                fill_data = mem_rdata;
                stall     = 1'b1;
            end
            S_DONE: begin
                fill_done = 1'b1;
                stall     = 1'b1;
            end
            default: begin
                stall = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Bench for dcache_miss_ctrl: transaction-level model checked every cycle
// plus directed scenarios with hand-computed stall lengths and addresses.
module tb_dcache_miss_ctrl;

    localparam int WORDS = 4;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        req_valid = 1'b0;
    logic        hit = 1'b0;
    logic        victim_dirty = 1'b0;
    logic [31:0] miss_addr = '0;
    logic [31:0] victim_addr = '0;
    logic [31:0] victim_word = '0;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic [1:0]  line_idx;
    logic        mem_req, mem_we, fill_we, fill_done, stall;
    logic [31:0] mem_addr, mem_wdata, fill_data, miss_count, wb_count;

    dcache_miss_ctrl #(.WORDS(WORDS), .ADDR_W(32)) dut (
        .CLK(CLK), .RESET(RESET), .req_valid(req_valid), .hit(hit),
        .victim_dirty(victim_dirty), .miss_addr(miss_addr),
        .victim_addr(victim_addr), .victim_word(victim_word),
        .line_idx(line_idx), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .fill_we(fill_we), .fill_data(fill_data),
        .fill_done(fill_done), .stall(stall), .miss_count(miss_count),
        .wb_count(wb_count)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // memory and cache-array responder
    int waits = 0;
    int wcnt = 0;
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            mem_rdata   = 32'hA0 + 32'(line_idx);
            victim_word = 32'hB0 + 32'(line_idx);
            if (waits == 0) begin
                mem_ack = 1'b1;
            end else if (mem_req) begin
                if (wcnt == waits) begin
                    mem_ack = 1'b1;
                    wcnt = 0;
                end else begin
                    mem_ack = 1'b0;
                    wcnt++;
                end
            end else begin
                mem_ack = 1'b0;
                wcnt = 0;
            end
        end
    end

    // transaction-level model: k = words acknowledged so far
    bit          busy = 0;
    bit          dirty = 0;
    int          k = 0;
    logic [31:0] fb = '0, wb = '0, mc = '0, wc = '0;
    int          preload_cnt = 0, preload_seen = 0;
    int          done_seen = 0;

    initial begin
        int total, j;
        bit wr_phase;
        bit e_req, e_we, e_fwe, e_done, e_stall;
        logic [31:0] e_addr;
        int e_idx;
        @(posedge CLK);
        forever begin
            @(negedge CLK);
            if (preload_cnt != preload_seen) begin
                mc = '1;
                preload_seen = preload_cnt;
            end
            total = dirty ? 2 * WORDS : WORDS;
            e_req = 0; e_we = 0; e_fwe = 0; e_done = 0; e_stall = 0;
            e_addr = '0; e_idx = 0; wr_phase = 0; j = 0;
            if (!busy) begin
                e_stall = req_valid && !hit;
            end else if (k == total) begin
                e_done = 1; e_stall = 1;
            end else begin
                e_stall = 1; e_req = 1;
                wr_phase = dirty && (k < WORDS);
                j = wr_phase ? k : k - (dirty ? WORDS : 0);
                e_we = wr_phase;
                e_idx = j;
                e_addr = (wr_phase ? wb : fb) + 32'(4 * j);
                e_fwe = !wr_phase && mem_ack;
            end
            chk("stall", 32'(stall), 32'(e_stall));
            chk("mem_req", 32'(mem_req), 32'(e_req));
            chk("mem_we", 32'(mem_we), 32'(e_we));
            chk("fill_we", 32'(fill_we), 32'(e_fwe));
            chk("fill_done", 32'(fill_done), 32'(e_done));
            chk("miss_count", miss_count, mc);
            chk("wb_count", wb_count, wc);
            if (e_req) begin
                chk("mem_addr", mem_addr, e_addr);
                chk("line_idx", 32'(line_idx), 32'(e_idx));
            end
            if (e_we) chk("mem_wdata", mem_wdata, victim_word);
            if (e_fwe) chk("fill_data", fill_data, mem_rdata);
            if (fill_done) done_seen++;
            if (RESET) begin
                busy = 0; k = 0; mc = '0; wc = '0;
            end else if (!busy) begin
                if (req_valid && !hit) begin
                    busy = 1; k = 0; dirty = victim_dirty;
                    fb = miss_addr & ~32'(4 * WORDS - 1);
                    wb = victim_addr & ~32'(4 * WORDS - 1);
                    if (mc != 32'hFFFF_FFFF) mc = mc + 1;
                    if (dirty && wc != 32'hFFFF_FFFF) wc = wc + 1;
                end
            end else if (k == total) begin
                busy = 0;
            end else if (mem_ack) begin
                k++;
            end
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    // called in the detect cycle; counts consecutive stall cycles
    task automatic measure(input bit mutate, output int n, output int fwe,
                           output int done_at, output logic [31:0] first_addr);
        n = 0; fwe = 0; done_at = -1; first_addr = '0;
        for (int c = 0; c < 200; c++) begin
            @(negedge CLK);
            if (!stall) break;
            if (c == 1) first_addr = mem_addr;
            if (fill_we) fwe++;
            if (fill_done) done_at = c;
            n++;
            cyc();
            if (c == 0) begin
                req_valid = 1'b0;
                if (mutate) begin
                    miss_addr   = 32'hDEAD_BEEF;
                    victim_addr = 32'h1357_9BDF;
                    hit         = 1'b1;
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int n, f, d, nd, second, ds;
        logic [31:0] a;
        repeat (3) cyc();
        @(negedge CLK);
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_fill_data", fill_data, 0);
        chk("rst_line_idx", 32'(line_idx), 0);
        chk("rst_miss_count", miss_count, 0);
        cyc();
        RESET = 1'b0;

        // hits and idle cycles: no stall, no traffic
        req_valid = 1'b1; hit = 1'b1; miss_addr = 32'h0000_0040;
        cyc(); cyc();
        @(negedge CLK);
        chk("hit_stall", 32'(stall), 0);
        chk("hit_mem_req", 32'(mem_req), 0);
        cyc();
        req_valid = 1'b0; hit = 1'b0;
        cyc();

        // clean miss, zero-wait memory
        waits = 0; victim_dirty = 1'b0;
        miss_addr = 32'h0000_1234; victim_addr = 32'h0000_5550;
        req_valid = 1'b1;
        measure(0, n, f, d, a);
        chk("clean_stall_len", 32'(n), 6);
        chk("clean_fill_we", 32'(f), 4);
        chk("clean_done_at", 32'(d), 5);
        chk("clean_addr0", a, 32'h0000_1230);
        chk("clean_miss_count", miss_count, 1);
        cyc();

        // dirty miss
        victim_dirty = 1'b1;
        victim_addr = 32'h0000_2008; miss_addr = 32'h0000_3000;
        req_valid = 1'b1;
        measure(0, n, f, d, a);
        chk("dirty_stall_len", 32'(n), 10);
        chk("dirty_fill_we", 32'(f), 4);
        chk("dirty_done_at", 32'(d), 9);
        chk("dirty_addr0", a, 32'h0000_2000);
        chk("dirty_wb_count", wb_count, 1);
        cyc();

        // clean miss with 2 wait cycles per word
        waits = 2; victim_dirty = 1'b0;
        miss_addr = 32'h4444_001C;
        req_valid = 1'b1;
        measure(0, n, f, d, a);
        chk("wait_stall_len", 32'(n), 14);
        chk("wait_fill_we", 32'(f), 4);
        chk("wait_addr0", a, 32'h4444_0010);
        cyc();

        // dirty miss, inputs scrambled after acceptance, 1 wait per word
        waits = 1; victim_dirty = 1'b1;
        victim_addr = 32'h0000_7FFC; miss_addr = 32'hFFFF_FFF4;
        req_valid = 1'b1;
        measure(1, n, f, d, a);
        chk("mut_stall_len", 32'(n), 18);
        chk("mut_fill_we", 32'(f), 4);
        chk("mut_addr0", a, 32'h0000_7FF0);
        hit = 1'b0;
        cyc();

        // back-to-back clean misses with req_valid held
        waits = 0; victim_dirty = 1'b0;
        miss_addr = 32'h0000_0100; req_valid = 1'b1;
        n = 0; nd = 0; second = -1;
        for (int c = 0; c < 100; c++) begin
            @(negedge CLK);
            if (!stall) break;
            n++;
            if (fill_done) begin
                nd++;
                if (second < 0) second = c + 1;
            end
            cyc();
            if (c + 1 == second) miss_addr = 32'h0000_0200;
            if (second >= 0 && c == second) req_valid = 1'b0;
        end
        chk("b2b_stall_len", 32'(n), 12);
        chk("b2b_dones", 32'(nd), 2);
        cyc();

        // reset in FILL after two words
        waits = 0; victim_dirty = 1'b0;
        miss_addr = 32'h0000_0600; req_valid = 1'b1;
        cyc();
        req_valid = 1'b0;
        cyc();
        cyc();
        RESET = 1'b1;
        ds = done_seen;
        cyc();
        RESET = 1'b0;
        @(negedge CLK);
        chk("rstmid_stall", 32'(stall), 0);
        chk("rstmid_mem_req", 32'(mem_req), 0);
        chk("rstmid_miss_count", miss_count, 0);
        chk("rstmid_line_idx", 32'(line_idx), 0);
        repeat (5) cyc();
        chk("rstmid_no_done", 32'(done_seen), 32'(ds));

        // miss counter saturation
        @(posedge CLK);
        #2;
        force dut.miss_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.miss_cnt_q;
        preload_cnt++;
        cyc();
        victim_dirty = 1'b1; victim_addr = 32'h0000_0A00;
        miss_addr = 32'h0000_0B00; req_valid = 1'b1;
        measure(0, n, f, d, a);
        chk("sat_miss_count", miss_count, 32'hFFFF_FFFF);
        chk("sat_wb_count", wb_count, 1);
        chk("sat_stall_len", 32'(n), 10);
        repeat (2) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dcache_miss_ctrl.md
# dcache_miss_ctrl

Miss-handling controller between the set-associative data cache (MEM stage) and the word-serial data memory backing store. On a load/store miss it stalls the pipeline, writes back the dirty victim line word by word, refills the missing line word by word, then signals the cache to commit tag/valid. It also keeps saturating miss and write-back event counters.

## Interface
- WORDS, 4, words per cache line; power of two, 2..16
- ADDR_W, 32, byte-address width
- CLK  in  1  rising-edge clock
- RESET  in  1  synchronous, active-high
- req_valid  in  1  MEM-stage load or store present this cycle
- hit  in  1  cache lookup hit for the current request
- victim_dirty  in  1  selected victim line is valid and dirty
- miss_addr  in  ADDR_W  byte address of the missing access
- victim_addr  in  ADDR_W  any byte address within the victim line
- victim_word  in  32  victim-line word at index line_idx (combinational from cache)
- line_idx  out  log2(WORDS)  word index currently transferred
- mem_req  out  1  memory request valid
- mem_we  out  1  1 = write (write-back), 0 = read (fill)
- mem_addr  out  ADDR_W  word-aligned memory address
- mem_wdata  out  32  write-back data
- mem_rdata  in  32  fill data, valid when mem_ack is high
- mem_ack  in  1  memory accepts or completes the request this cycle
- fill_we  out  1  write fill_data into cache line word line_idx
- fill_data  out  32  word to write into the cache
- fill_done  out  1  one-cycle pulse: set tag/valid, clear dirty
- stall  out  1  freeze the pipeline
- miss_count  out  32  saturating count of misses
- wb_count  out  32  saturating count of dirty write-backs

## Operation
- States: IDLE, WB, FILL, DONE.
- IDLE: if req_valid && !hit, latch the line bases fill_base = {miss_addr[ADDR_W-1:OFF],0} and wb_base likewise from victim_addr, where OFF = log2(WORDS)+2. Clear the word counter. Go to WB if victim_dirty, else go to FILL. Increment miss_count, and increment wb_count if the miss is dirty.
- WB: mem_req=1, mem_we=1, mem_addr = wb_base + 4·line_idx, mem_wdata = victim_word. On mem_ack, increment the counter. On the ack of the last word, wrap the counter to 0 and go to FILL.
- FILL: mem_req=1, mem_we=0, mem_addr = fill_base + 4·line_idx. fill_we = mem_ack and fill_data = mem_rdata. On mem_ack, increment the counter. On the ack of the last word, go to DONE.
- DONE: fill_done=1 for exactly one cycle, then go to IDLE.
- stall = (IDLE && req_valid && !hit) || state != IDLE.
- While mem_req is high, mem_addr, mem_we and mem_wdata stay stable until mem_ack arrives.
- mem_ack is ignored in IDLE and DONE.
- Address arithmetic is modulo 2^ADDR_W. The line base already clears offset bits, so there is no carry across the line.
- Counters saturate at 0xFFFFFFFF.
- Latched addresses are used for the whole transaction. Changes on miss_addr, victim_addr or req_valid after the miss is accepted are ignored; the transaction always completes.
- hit is sampled only in IDLE.

## Timing
- Reset values: state IDLE, line_idx 0, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, fill_we 0, fill_data 0, fill_done 0, stall 0, both counters 0.
- RESET asserted mid-transaction: the controller returns to IDLE on the next edge and drops any outstanding request. Partial fill words in the cache are left invalid because fill_done never fires.
- With mem_ack tied high (zero-wait memory):
  - Clean miss: stall high for WORDS+2 cycles (6 when WORDS=4), namely the detect cycle, WORDS fill cycles and DONE. The cache hits on the cycle after DONE.
  - Dirty miss: stall high for 2·WORDS+2 cycles (10 when WORDS=4).
- Each wait cycle of memory (mem_req high, mem_ack low) adds exactly one stall cycle.
- If a hit occurs or req_valid is low in IDLE, stall stays 0 and there is no memory traffic.
- A back-to-back miss on the cycle after DONE is accepted normally with no idle gap.

## Test plan
- Clean miss, miss_addr=0x0000_1234, zero-wait memory returning 0xA0..0xA3 -> mem_addr 0x1230, 0x1234, 0x1238, 0x123C; fill_we with 0xA0..0xA3 at line_idx 0..3; fill_done in cycle 5; stall high for 6 cycles; miss_count=1.
- Dirty miss, victim_addr=0x0000_2008, miss_addr=0x0000_3000 -> writes to 0x2000..0x200C with victim_word values, then reads 0x3000..0x300C; stall 10 cycles; wb_count=1.
- Memory with 2 wait cycles per word, clean miss -> address held stable through the waits; stall = 6+8 = 14 cycles; exactly 4 fill_we pulses.
- RESET asserted in FILL after 2 words -> next cycle state IDLE, mem_req=0, stall=0, fill_done never pulses, counters 0.
- miss_addr changed and req_valid dropped during WB -> original addresses still used; the full transaction completes.
- miss_count preloaded to 0xFFFFFFFF by force, then another miss -> count stays 0xFFFFFFFF.
